// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the lab core
module multi_cycle_ctrl #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [6:0]       opcode_i,
    input  logic             imem_ack_i,
    output logic             imem_req_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       ALUOp_o,
    output logic             ALUSrc_o,
    output logic             RegWrite_o,
    output logic             busy_o,
    output logic             illegal_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [7:0] WAIT_MAX  = 8'(TIMEOUT);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic             alu_src_q, alu_src_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        alu_op_d  = alu_op_q;
        alu_src_d = alu_src_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                // wait_q counts FETCH cycles already spent without an ack
                if (imem_ack_i) begin
                    state_d = S_DECODE;
                    wait_d  = '0;
                end else if (wait_q >= WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (opcode_i == OP_R) begin
                    alu_op_d  = 2'b10;
                    alu_src_d = 1'b0;
                    state_d   = S_EXECUTE;
                end else if (opcode_i == OP_I) begin
                    alu_op_d  = 2'b11;
                    alu_src_d = 1'b1;
                    state_d   = S_EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXECUTE: state_d = S_WRITEBACK;
            S_WRITEBACK: begin
                retired_d = retired_q + CNT_W'(1);
                wait_d    = '0;
                state_d   = start_i ? S_FETCH : S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            alu_op_q  <= '0;
            alu_src_q <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            alu_op_q  <= alu_op_d;
            alu_src_q <= alu_src_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            retired_q <= retired_d;
        end
    end

    logic ex_wb;
    assign ex_wb = (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);

    assign imem_req_o = (state_q == S_FETCH);
    assign ir_we_o    = (state_q == S_FETCH) && imem_ack_i;
    assign pc_we_o    = (state_q == S_WRITEBACK);
    assign RegWrite_o = (state_q == S_WRITEBACK);
    assign ALUOp_o    = ex_wb ? alu_op_q : 2'b00;
    assign ALUSrc_o   = ex_wb ? alu_src_q : 1'b0;
    assign busy_o     = (state_q == S_FETCH) || (state_q == S_DECODE) || ex_wb;
    assign illegal_o  = illegal_q;
    assign timeout_o  = timeout_q;
    assign retired_o  = retired_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - directed self-checking bench for multi_cycle_ctrl (CNT_W=2, TIMEOUT=4)
module tb_multi_cycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic [6:0] opcode_i = 7'd0;
    logic       imem_ack_i = 1'b0;
    logic       imem_req_o, ir_we_o, pc_we_o, ALUSrc_o, RegWrite_o;
    logic       busy_o, illegal_o, timeout_o;
    logic [1:0] ALUOp_o;
    logic [1:0] retired_o;

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BAD = 7'b0000011;

    multi_cycle_ctrl #(.CNT_W(2), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .opcode_i(opcode_i),
        .imem_ack_i(imem_ack_i), .imem_req_o(imem_req_o), .ir_we_o(ir_we_o),
        .pc_we_o(pc_we_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o),
        .RegWrite_o(RegWrite_o), .busy_o(busy_o), .illegal_o(illegal_o),
        .timeout_o(timeout_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs packed for whole-vector checks:
    // {imem_req, ir_we, pc_we, ALUOp[1:0], ALUSrc, RegWrite, busy, illegal, timeout, retired[1:0]}
    function automatic logic [31:0] outs();
        return {20'd0, imem_req_o, ir_we_o, pc_we_o, ALUOp_o, ALUSrc_o, RegWrite_o,
                busy_o, illegal_o, timeout_o, retired_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic do_reset();
        tick();
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
    endtask

    initial begin
        // reset with start held high
        start_i = 1'b1;
        rst_i   = 1'b0;
        tick();
        tick();
        check("reset_outs", outs(), 32'h0);
        rst_i = 1'b1;
        #1;
        check("post_release_idle", outs(), 32'h0);
        tick();
        check("first_req", {imem_req_o, busy_o}, 2'b11);

        // R-type, immediate ack
        imem_ack_i = 1'b1;
        opcode_i   = OP_R;
        #1;
        check("r_ir_we", ir_we_o, 1'b1);
        tick();
        check("r_decode", {imem_req_o, ir_we_o, busy_o, ALUOp_o}, 5'b00100);
        imem_ack_i = 1'b0;
        start_i    = 1'b0;
        tick();
        check("r_execute", {ALUOp_o, ALUSrc_o, RegWrite_o, pc_we_o}, 5'b10000);
        tick();
        check("r_writeback", {ALUOp_o, ALUSrc_o, RegWrite_o, pc_we_o, busy_o}, 6'b100111);
        check("r_retired_wb", retired_o, 2'd0);
        tick();
        check("r_idle", {RegWrite_o, pc_we_o, busy_o, ALUOp_o}, 5'b00000);
        check("r_retired", retired_o, 2'd1);

        // I-type back-to-back, ack on FETCH cycle 4 (the timeout boundary)
        do_reset();
        opcode_i = OP_I;
        start_i  = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            for (int c = 1; c <= 3; c++) begin
                check($sformatf("i%0d_wait%0d", k, c), {imem_req_o, ir_we_o, timeout_o}, 3'b100);
                tick();
            end
            imem_ack_i = 1'b1;
            #1;
            check($sformatf("i%0d_ack4", k), {imem_req_o, ir_we_o}, 2'b11);
            tick();
            imem_ack_i = 1'b0;
            check($sformatf("i%0d_decode", k), {imem_req_o, busy_o, ALUOp_o}, 4'b0100);
            tick();
            check($sformatf("i%0d_exec", k), {ALUOp_o, ALUSrc_o, RegWrite_o}, 4'b1110);
            tick();
            check($sformatf("i%0d_wb", k), {ALUOp_o, ALUSrc_o, RegWrite_o, pc_we_o}, 5'b11111);
            if (k == 2) start_i = 1'b0;
            tick();
            check($sformatf("i%0d_retired", k), retired_o, 32'(k + 1));
            check($sformatf("i%0d_next_req", k), imem_req_o, (k == 2) ? 1'b0 : 1'b1);
        end
        check("i_timeout_clear", timeout_o, 1'b0);

        // illegal opcode
        do_reset();
        start_i = 1'b1;
        tick();
        imem_ack_i = 1'b1;
        opcode_i   = OP_BAD;
        tick();
        imem_ack_i = 1'b0;
        tick();
        check("ill_halt", outs(), 32'h8);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("ill_stay%0d", c), outs(), 32'h8);
        end

        // timeout with no ack
        do_reset();
        start_i = 1'b1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("to_fetch%0d", c), {imem_req_o, busy_o, timeout_o}, 3'b110);
            tick();
        end
        check("to_halt", outs(), 32'h4);
        imem_ack_i = 1'b1;
        tick();
        check("to_ack_ignored", outs(), 32'h4);
        imem_ack_i = 1'b0;

        // retired counter wrap: 1,2,3,0,1
        do_reset();
        opcode_i   = OP_R;
        imem_ack_i = 1'b1;
        start_i    = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            tick();
            tick();
            check($sformatf("wrap%0d_wb", k), {RegWrite_o, pc_we_o}, 2'b11);
            if (k == 4) start_i = 1'b0;
            tick();
            check($sformatf("wrap%0d_cnt", k), retired_o, 32'((k + 1) % 4));
        end
        check("wrap_idle", busy_o, 1'b0);

        // asynchronous abort in EXECUTE
        start_i = 1'b1;
        tick();
        tick();
        tick();
        check("abort_exec", {ALUOp_o, busy_o, retired_o}, 5'b10101);
        #1;
        rst_i = 1'b0;
        #1;
        check("abort_async", outs(), 32'h0);
        tick();
        check("abort_no_wb", outs(), 32'h0);
        rst_i = 1'b1;
        imem_ack_i = 1'b0;
        start_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
